// File: rtl/sobel_gradient_core_pkg.sv
// sobel_pkg: shared constants, types and window accessor for the Sobel gradient core
package sobel_pkg;
    localparam int PIX_W      = 8;
    localparam int WIN_W      = 72;
    localparam int GRAD_W     = 11;
    localparam int DIM_W      = 11;
    localparam int MAX_WIDTH  = 1920;
    localparam int MAX_HEIGHT = 1080;

    typedef logic [PIX_W-1:0]         pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} frame_state_t;

    // Byte k of the window is pixel (col,row) with k = 3*col + row
    function automatic pix_t win_byte(input logic [WIN_W-1:0] window, input int col, input int row);
        return window[PIX_W*(3*col+row) +: PIX_W];
    endfunction
endpackage

// File: rtl/sobel_gradient_core_if.sv
// sobel_gradient_core_if: window input stream and result pixel output stream
interface sobel_gradient_core_if
    import sobel_pkg::*;
;
    logic [WIN_W-1:0] window_in;
    logic             valid_in;
    pix_t             pixel_out;
    logic             valid_out;
    logic             eol_out;
    logic             eof_out;

    modport master(output window_in, valid_in, input pixel_out, valid_out, eol_out, eof_out);
    modport slave(input window_in, valid_in, output pixel_out, valid_out, eol_out, eof_out);
endinterface

// File: rtl/sobel_pos_counter.sv
// sobel_pos_counter: col/row tracking, border/eol/eof tags and frame state machine
module sobel_pos_counter
    import sobel_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic             accept_o,
    output logic             border_o,
    output logic             eol_o,
    output logic             eof_o,
    output logic             overflow_o
);
    frame_state_t     state_q, state_d;
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [1:0]       drain_q, drain_d;
    logic             ovf_q, ovf_d;
    logic             last_row;

    assign last_row   = row_q == height_i - DIM_W'(1);
    assign eol_o      = col_q == width_i - DIM_W'(1);
    assign eof_o      = eol_o & last_row;
    assign border_o   = (row_q == '0) | last_row | (col_q == '0) | eol_o;
    assign accept_o   = valid_i && (state_q != DONE);
    assign overflow_o = ovf_q;

    // Position advance on accepted windows; DONE drops input and drains for 3 cycles
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = '0;
        ovf_d   = ovf_q;
        if (accept_o) begin
            col_d   = eol_o ? '0 : col_q + DIM_W'(1);
            row_d   = eol_o ? (last_row ? '0 : row_q + DIM_W'(1)) : row_q;
            state_d = eof_o ? DONE : ACTIVE;
        end
        if (state_q == DONE) begin
            ovf_d   = ovf_q | valid_i;
            drain_d = drain_q + 2'd1;
            state_d = (drain_q == 2'd2) ? IDLE : DONE;
        end
    end

    // Frame state and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: rtl/sobel_gradient_core.sv
// sobel_gradient_core: 3-stage Sobel |Gx|+|Gy| pipeline with thresholding and frame markers
module sobel_gradient_core
    import sobel_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    sobel_gradient_core_if.slave  s,
    input  logic [DIM_W-1:0]      image_width,
    input  logic [DIM_W-1:0]      image_height,
    input  pix_t                  threshold,
    input  logic                  thresh_en,
    input  logic                  border_zero,
    output logic                  overflow_err
);
    typedef logic [PIX_W+1:0] sum_t;

    function automatic sum_t wsum(input pix_t a, input pix_t b, input pix_t c);
        return sum_t'(a) + sum_t'({b, 1'b0}) + sum_t'(c);
    endfunction

    logic              accept, tag_border, tag_eol, tag_eof;
    sum_t              lx_d, rx_d, ty_d, by_d, lx_q, rx_q, ty_q, by_q;
    sum_t              ax_d, ay_d, ax_q, ay_q;
    grad_t             gx, gy;
    logic [GRAD_W-1:0] mag;
    pix_t              pix_d, pix_q;
    logic              v1_q, v2_q, v3_q;
    logic [2:0]        tag1_q, tag2_q;
    logic              eol_q, eof_q;

    sobel_pos_counter u_pos (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_i    (s.valid_in),
        .width_i    (image_width),
        .height_i   (image_height),
        .accept_o   (accept),
        .border_o   (tag_border),
        .eol_o      (tag_eol),
        .eof_o      (tag_eof),
        .overflow_o (overflow_err)
    );

    // Weighted column and row sums, then absolute gradients, then magnitude and result
    always_comb begin
        lx_d  = wsum(win_byte(s.window_in, 0, 0), win_byte(s.window_in, 0, 1), win_byte(s.window_in, 0, 2));
        rx_d  = wsum(win_byte(s.window_in, 2, 0), win_byte(s.window_in, 2, 1), win_byte(s.window_in, 2, 2));
        ty_d  = wsum(win_byte(s.window_in, 0, 0), win_byte(s.window_in, 1, 0), win_byte(s.window_in, 2, 0));
        by_d  = wsum(win_byte(s.window_in, 0, 2), win_byte(s.window_in, 1, 2), win_byte(s.window_in, 2, 2));
        gx    = grad_t'({1'b0, rx_q}) - grad_t'({1'b0, lx_q});
        gy    = grad_t'({1'b0, by_q}) - grad_t'({1'b0, ty_q});
        ax_d  = sum_t'(gx[GRAD_W-1] ? -gx : gx);
        ay_d  = sum_t'(gy[GRAD_W-1] ? -gy : gy);
        mag   = {1'b0, ax_q} + {1'b0, ay_q};
        pix_d = thresh_en ? ((mag >= {3'b0, threshold}) ? '1 : '0)
                          : ((|mag[GRAD_W-1:PIX_W]) ? '1 : mag[PIX_W-1:0]);
        pix_d = (border_zero && tag2_q[2]) ? '0 : pix_d;
    end

    // Pipeline registers; data advances only with its valid so outputs hold through bubbles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {v1_q, v2_q, v3_q} <= '0;
            {lx_q, rx_q, ty_q, by_q} <= '0;
            {ax_q, ay_q} <= '0;
            {tag1_q, tag2_q} <= '0;
            {pix_q, eol_q, eof_q} <= '0;
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (accept) begin
                {lx_q, rx_q, ty_q, by_q} <= {lx_d, rx_d, ty_d, by_d};
                tag1_q <= {tag_border, tag_eol, tag_eof};
            end
            if (v1_q) begin
                {ax_q, ay_q} <= {ax_d, ay_d};
                tag2_q <= tag1_q;
            end
            if (v2_q) {pix_q, eol_q, eof_q} <= {pix_d, tag2_q[1:0]};
        end
    end

    assign s.pixel_out = pix_q;
    assign s.valid_out = v3_q;
    assign s.eol_out   = eol_q;
    assign s.eof_out   = eof_q;
endmodule
